// File: rtl/egress_vlan_tagger.sv
// Egress 802.1Q tagger: inserts a 4-byte VLAN tag after the MAC addresses of a 1G byte stream.
// Optional tagged-frame counter enabled by defining EGRESS_VLAN_STATS_EN.
package egress_vlan_tagger_pkg;
  typedef struct packed {
    logic        start;
    logic        data_valid;
    logic [2:0]  bytes_valid;
    logic [31:0] data;
  } EthernetTxBus;
endpackage

module egress_vlan_tagger
  import egress_vlan_tagger_pkg::*;
#(
  parameter logic [15:0] TPID = 16'h8100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  EthernetTxBus up_bus,
  output logic         up_ready,
  input  logic         mac_ready,
  output EthernetTxBus mac_bus,
  input  logic         tag_en,
  input  logic [11:0]  tag_vid,
  input  logic [2:0]   tag_pcp,
  output logic [31:0]  tagged_count
);

  typedef enum logic [2:0] {IDLE, HDR, PASS, TAG, BODY, DRAIN} state_t;

  state_t       r_state, w_state_next;
  logic [3:0]   r_cnt, w_cnt_next;
  logic         r_lat_en, w_lat_en_next;
  logic [11:0]  r_lat_vid, w_lat_vid_next;
  logic [2:0]   r_lat_pcp, w_lat_pcp_next;
  logic         r_in_done, w_in_done_next;
  EthernetTxBus r_out, w_out_next;
  logic [7:0]   r_fifo [4];
  logic [1:0]   r_wr_ptr, r_rd_ptr;
  logic [2:0]   r_occ;
  logic         w_push, w_pop;
  logic         w_unused;

  assign w_unused = ^{up_bus.data[31:8], up_bus.bytes_valid};
  assign up_ready = rst_n & mac_ready & (r_state == IDLE);
  assign mac_bus  = r_out;

  function automatic EthernetTxBus byte_beat(input logic [7:0] b);
    EthernetTxBus beat;
    beat             = '0;
    beat.data_valid  = 1'b1;
    beat.bytes_valid = 3'd1;
    beat.data        = {24'd0, b};
    return beat;
  endfunction

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_lat_en_next  = r_lat_en;
    w_lat_vid_next = r_lat_vid;
    w_lat_pcp_next = r_lat_pcp;
    w_in_done_next = r_in_done;
    w_out_next     = '0;
    w_push         = 1'b0;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        if (up_bus.start) begin
          w_lat_en_next    = tag_en;
          w_lat_vid_next   = tag_vid;
          w_lat_pcp_next   = tag_pcp;
          w_in_done_next   = 1'b0;
          w_cnt_next       = 4'd1;
          w_out_next       = byte_beat(up_bus.data[7:0]);
          w_out_next.start = 1'b1;
          w_state_next     = HDR;
        end
      end
      HDR: begin
        if (up_bus.data_valid) begin
          w_out_next = byte_beat(up_bus.data[7:0]);
          w_cnt_next = r_cnt + 4'd1;
          if (r_cnt == 4'd11) begin
            w_cnt_next   = 4'd0;
            w_state_next = r_lat_en ? TAG : PASS;
          end
        end else begin
          w_state_next = IDLE;
        end
      end
      PASS: begin
        if (up_bus.data_valid) w_out_next = byte_beat(up_bus.data[7:0]);
        else                   w_state_next = IDLE;
      end
      TAG: begin
        case (r_cnt[1:0])
          2'd0:    w_out_next = byte_beat(TPID[15:8]);
          2'd1:    w_out_next = byte_beat(TPID[7:0]);
          2'd2:    w_out_next = byte_beat({r_lat_pcp, 1'b0, r_lat_vid[11:8]});
          default: w_out_next = byte_beat(r_lat_vid[7:0]);
        endcase
        // Short frames (12..15 bytes) may end while the tag is still being emitted.
        if (up_bus.data_valid && !r_in_done) w_push = 1'b1;
        else                                 w_in_done_next = 1'b1;
        w_cnt_next = r_cnt + 4'd1;
        if (r_cnt[1:0] == 2'd3) begin
          w_cnt_next = 4'd0;
          if (w_in_done_next) w_state_next = (r_occ == 3'd0) ? IDLE : DRAIN;
          else                w_state_next = BODY;
        end
      end
      BODY: begin
        w_pop      = 1'b1;
        w_out_next = byte_beat(r_fifo[r_rd_ptr]);
        if (up_bus.data_valid) w_push = 1'b1;
        else                   w_state_next = DRAIN;
      end
      DRAIN: begin
        w_pop      = 1'b1;
        w_out_next = byte_beat(r_fifo[r_rd_ptr]);
        if (r_occ == 3'd1) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_lat_en  <= 1'b0;
      r_lat_vid <= '0;
      r_lat_pcp <= '0;
      r_in_done <= 1'b0;
      r_out     <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_lat_en  <= w_lat_en_next;
      r_lat_vid <= w_lat_vid_next;
      r_lat_pcp <= w_lat_pcp_next;
      r_in_done <= w_in_done_next;
      r_out     <= w_out_next;
      if (w_push) begin
        r_fifo[r_wr_ptr] <= up_bus.data[7:0];
        r_wr_ptr         <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      r_occ <= r_occ + {2'd0, w_push} - {2'd0, w_pop};
    end
  end

`ifdef EGRESS_VLAN_STATS_EN
  logic        w_enter_tag;
  logic [31:0] r_tagged_count;

  assign w_enter_tag  = (r_state == HDR) && (w_state_next == TAG);
  assign tagged_count = r_tagged_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      r_tagged_count <= '0;
    else if (w_enter_tag && (r_tagged_count != '1))  r_tagged_count <= r_tagged_count + 32'd1;
  end
`else
  assign tagged_count = '0;
`endif

endmodule

// File: tb/tb_egress_vlan_tagger.sv
// Directed bench for egress_vlan_tagger: pass-through, tagging, runts, back-to-back, reset abort.
module tb_egress_vlan_tagger;
  import egress_vlan_tagger_pkg::*;

`ifdef EGRESS_VLAN_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  EthernetTxBus up_bus;
  logic         up_ready;
  logic         mac_ready;
  EthernetTxBus mac_bus;
  logic         tag_en;
  logic [11:0]  tag_vid;
  logic [2:0]   tag_pcp;
  logic [31:0]  tagged_count;

  egress_vlan_tagger #(.TPID(16'h8100)) dut (
    .clk(clk), .rst_n(rst_n), .up_bus(up_bus), .up_ready(up_ready),
    .mac_ready(mac_ready), .mac_bus(mac_bus), .tag_en(tag_en),
    .tag_vid(tag_vid), .tag_pcp(tag_pcp), .tagged_count(tagged_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  int cap_starts, out_start_cyc, in_start_cyc, ready_low, inv_bad;
  logic [31:0] exp_count;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mac_bus.data_valid) begin
        cap_q.push_back(mac_bus.data[7:0]);
        if (mac_bus.data[31:8] != 24'd0 || mac_bus.bytes_valid != 3'd1) inv_bad++;
      end else if (mac_bus.bytes_valid != 3'd0) begin
        inv_bad++;
      end
      if (mac_bus.start) begin
        cap_starts++;
        out_start_cyc = cyc;
      end
      if (!up_ready) ready_low++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_test();
    cap_q.delete();
    exp_q.delete();
    cap_starts = 0;
    ready_low  = 0;
  endtask

  task automatic add_expected(input int n, input logic en, input logic [11:0] vid,
                              input logic [2:0] pcp, input logic [7:0] seed);
    for (int i = 0; i < n; i++) begin
      if (en && i == 12) begin
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h00);
        exp_q.push_back({pcp, 1'b0, vid[11:8]});
        exp_q.push_back(vid[7:0]);
      end
      exp_q.push_back(seed + 8'(i));
    end
    if (en && n >= 12) exp_count = (exp_count == 32'hFFFF_FFFF) ? exp_count : exp_count + 32'(STATS);
  endtask

  // Called at posedge+1; returns at posedge+1 after the last byte or the reset assertion.
  task automatic drive_frame(input int n, input logic en, input logic [11:0] vid,
                             input logic [2:0] pcp, input logic [7:0] seed,
                             input int stray_at, input int abort_at);
    int w = 0;
    while (!up_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!up_ready) begin
      check("up_ready_wait", 32'd0, 32'd1);
      return;
    end
    in_start_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        rst_n  = 1'b0;
        up_bus = '0;
        #1;
        check("rst_mac_bus", 32'(mac_bus), 32'd0);
        check("rst_up_ready", 32'(up_ready), 32'd0);
        check("rst_count", tagged_count, 32'd0);
        return;
      end
      up_bus.start       = (i == 0) || (i == stray_at);
      up_bus.data_valid  = 1'b1;
      up_bus.bytes_valid = 3'd1;
      up_bus.data        = {24'd0, seed + 8'(i)};
      tag_en  = (i == 0) ? en  : ~en;
      tag_vid = (i == 0) ? vid : ~vid;
      tag_pcp = (i == 0) ? pcp : ~pcp;
      @(posedge clk); #1;
    end
    up_bus = '0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!(up_ready && !mac_bus.data_valid) && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    if (!(up_ready && !mac_bus.data_valid)) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    up_bus    = '0;
    mac_ready = 1'b1;
    tag_en    = 1'b0;
    tag_vid   = '0;
    tag_pcp   = '0;
    inv_bad   = 0;
    exp_count = '0;
    start_test();
    repeat (3) @(negedge clk);
    check("reset_mac_bus", 32'(mac_bus), 32'd0);
    check("reset_up_ready", 32'(up_ready), 32'd0);
    check("reset_count", tagged_count, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Untagged 64-byte frame with a stray start mid-frame.
    start_test();
    add_expected(64, 1'b0, 12'h000, 3'd0, 8'h00);
    drive_frame(64, 1'b0, 12'h000, 3'd0, 8'h00, 20, -1);
    wait_idle();
    compare_stream("plain");
    check("plain_latency", 32'(out_start_cyc - in_start_cyc), 32'd1);
    check("plain_starts", 32'(cap_starts), 32'd1);
    check("plain_ready_low", 32'(ready_low), 32'd64);
    check("plain_count", tagged_count, exp_count);

    // Tagged 64-byte frame: vid 123, pcp 5 -> 81 00 A1 23.
    start_test();
    add_expected(64, 1'b1, 12'h123, 3'd5, 8'h40);
    drive_frame(64, 1'b1, 12'h123, 3'd5, 8'h40, -1, -1);
    wait_idle();
    compare_stream("tag64");
    check("tag64_latency", 32'(out_start_cyc - in_start_cyc), 32'd1);
    check("tag64_ready_low", 32'(ready_low), 32'd67);
    check("tag64_count", tagged_count, exp_count);

    // Tagged runt of 10 bytes passes unchanged.
    start_test();
    add_expected(10, 1'b0, 12'h000, 3'd0, 8'h90);
    drive_frame(10, 1'b1, 12'h456, 3'd2, 8'h90, -1, -1);
    wait_idle();
    compare_stream("runt");
    check("runt_ready_low", 32'(ready_low), 32'd10);
    check("runt_count", tagged_count, exp_count);

    // Back-to-back tagged frames, including a 14-byte one ending inside the tag.
    start_test();
    add_expected(64, 1'b1, 12'hFFF, 3'd7, 8'h10);
    add_expected(20, 1'b1, 12'h001, 3'd0, 8'hC0);
    add_expected(14, 1'b1, 12'h5A5, 3'd3, 8'h70);
    drive_frame(64, 1'b1, 12'hFFF, 3'd7, 8'h10, -1, -1);
    drive_frame(20, 1'b1, 12'h001, 3'd0, 8'hC0, -1, -1);
    drive_frame(14, 1'b1, 12'h5A5, 3'd3, 8'h70, -1, -1);
    wait_idle();
    compare_stream("b2b");
    check("b2b_starts", 32'(cap_starts), 32'd3);
    check("b2b_ready_low", 32'(ready_low), 32'd107);
    check("b2b_count", tagged_count, exp_count);

    // Reset at byte 30 of a tagged frame, then a clean 60-byte tagged frame.
    drive_frame(64, 1'b1, 12'h321, 3'd1, 8'h00, -1, 30);
    repeat (2) @(posedge clk);
    #1;
    check("abort_held_bus", 32'(mac_bus), 32'd0);
    rst_n     = 1'b1;
    exp_count = '0;
    @(posedge clk); #1;
    start_test();
    add_expected(60, 1'b1, 12'hABC, 3'd3, 8'h20);
    drive_frame(60, 1'b1, 12'hABC, 3'd3, 8'h20, -1, -1);
    wait_idle();
    compare_stream("post_rst");
    check("post_rst_count", tagged_count, exp_count);

`ifdef EGRESS_VLAN_STATS_EN
    // Counter saturation from a preset near the top.
    dut.r_tagged_count = 32'hFFFF_FFFE;
    exp_count = 32'hFFFF_FFFE;
    for (int f = 0; f < 3; f++) begin
      start_test();
      add_expected(16, 1'b1, 12'h0F0, 3'd4, 8'(f * 16));
      drive_frame(16, 1'b1, 12'h0F0, 3'd4, 8'(f * 16), -1, -1);
      wait_idle();
      compare_stream($sformatf("sat%0d", f));
      check($sformatf("sat%0d_count", f), tagged_count, 32'hFFFF_FFFF);
    end
`endif

    check("beat_invariants", 32'(inv_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/egress_vlan_tagger.md
EGRESS_VLAN_TAGGER -- requirements
Module: egress_vlan_tagger

Interface
REQ-001 SHALL have parameter TPID, default 16'h8100, meaning the tag protocol identifier that is inserted.
REQ-002 SHALL have port clk, input, 1 bit: the per-port transmit clock; the whole block is synchronous to it.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port up_bus, input, EthernetTxBus: the byte stream from the egress FIFO, 1G lane only, data[7:0] with bytes_valid=1.
REQ-005 SHALL have port up_ready, output, 1 bit: flow control to the egress FIFO; the FIFO starts a frame only while this is high.
REQ-006 SHALL have port mac_ready, input, 1 bit: MAC transmit-ready.
REQ-007 SHALL have port mac_bus, output, EthernetTxBus: the stream to the MAC.
REQ-008 SHALL have port tag_en, input, 1 bit: insert an 802.1Q tag into the frame.
REQ-009 SHALL have ports tag_vid (input, 12 bits) and tag_pcp (input, 3 bits): the VLAN ID and priority.
REQ-010 SHALL have port tagged_count, output, 32 bits: the count of tagged frames.

Function
REQ-011 SHALL drive up_ready = mac_ready AND (state==IDLE) combinationally.
REQ-012 SHALL latch tag_en, tag_vid and tag_pcp on the cycle up_bus.start=1; later changes SHALL NOT affect the frame in flight.
REQ-013 SHALL register every mac_bus field, giving exactly 1-cycle latency from up_bus to mac_bus for the start pulse and for bytes 0-11.
REQ-014 SHALL drive mac_bus.data[31:8]=0 and bytes_valid=1 on every valid output byte, and bytes_valid=0 otherwise.
REQ-015 SHALL implement states IDLE, HDR, PASS, TAG, BODY and DRAIN.
REQ-016 SHALL move from IDLE to HDR on up_bus.start, clearing the byte counter.
REQ-017 SHALL, in HDR, pass bytes through and count them; when byte 11 has passed it SHALL go to TAG if the latched tag_en=1, else to PASS.
REQ-018 SHALL, in HDR, go to IDLE with no tag inserted if data_valid falls before 12 bytes (runt frame passed through unchanged).
REQ-019 SHALL, in PASS, pass bytes through and return to IDLE on the first cycle data_valid=0.
REQ-020 SHALL, in TAG, emit TPID[15:8], TPID[7:0], {pcp,1'b0,vid[11:8]}, vid[7:0] on 4 consecutive cycles while pushing incoming bytes into a 4-entry byte delay FIFO.
REQ-021 SHALL, in BODY, output from the delay FIFO while pushing input into it (constant 4-byte occupancy); on the first data_valid=0 it SHALL go to DRAIN.
REQ-022 SHALL, in DRAIN, output the remaining FIFO bytes on consecutive cycles, then go to IDLE.
REQ-023 SHALL keep mac_bus.data_valid continuous with no gaps, so a tagged frame of N input bytes (N>=12) yields exactly N+4 output bytes.
REQ-024 SHALL ignore up_bus.start outside IDLE, with no state or output change; the FIFO SHALL never overflow under legal upstream behaviour.
REQ-025 SHALL ignore mac_ready mid-frame; it gates frame starts only.

Reset
REQ-026 SHALL, while rst_n=0, force state=IDLE, clear the FIFO, the counter and all latched tag fields, and drive every mac_bus field, up_ready and tagged_count to 0.
REQ-027 SHALL abandon a frame in flight on reset; the first frame after rst_n rises SHALL be handled normally.

Configuration
REQ-028 SHALL use macro EGRESS_VLAN_STATS_EN to control tagged_count.
REQ-029 SHALL, when EGRESS_VLAN_STATS_EN is defined, increment tagged_count on entry to TAG and saturate it at 32'hFFFFFFFF.
REQ-030 SHALL, when EGRESS_VLAN_STATS_EN is undefined, tie tagged_count to 0 and build no counter logic.

Verification
REQ-031 SHALL cover: tag_en=0, 64-byte frame -> identical 64 bytes out, start and data delayed 1 cycle.
REQ-032 SHALL cover: tag_en=1, vid=12'h123, pcp=5, 64-byte frame -> 68 bytes out, bytes 12-15 = 81 00 A1 23, out byte 16 = in byte 12.
REQ-033 SHALL cover: tag_en=1, 10-byte runt -> 10 bytes out unchanged, tagged_count unchanged.
REQ-034 SHALL cover: back-to-back tagged frames with mac_ready=1 -> up_ready low from start until the DRAIN end, with no byte lost or reordered.
REQ-035 SHALL cover: rst_n pulsed low at byte 30 of a tagged frame -> outputs 0 at once; next 60-byte tagged frame -> 64 bytes out correct.
REQ-036 SHALL cover: with EGRESS_VLAN_STATS_EN, counter preset near 32'hFFFFFFFE and 3 tagged frames -> count holds at 32'hFFFFFFFF.
